uart_rx_8n1: RTL and testbench

UART_RX_8N1 -- requirements
Module: uart_rx_8n1

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sync.sv | 55 +++++
 rtl/uart_rx_8n1.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_8n1.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and helpers
//
// Purpose : constants shared by the UART receiver and transmitter.
// Contents: default bit period, frame geometry, receiver state encoding,
//           2-of-3 majority helper used for bit decisions.
package uart_pkg;

    // 12 MHz system clock / 9600 baud
    localparam int UART_CLKS_PER_BIT_DEFAULT = 1250;
    localparam int UART_DATA_BITS            = 8;

    // Receiver state encoding (plain constants so older tools can read it)
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Status snapshot of one received frame
    typedef struct packed {
        logic [UART_DATA_BITS-1:0] data;
        logic                      stop_ok;
    } uart_frame_t;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx synchronizer with qualified falling-edge detect
//
// Purpose : bring the asynchronous rx pin into the clk domain and flag
//           high-to-low transitions of the synchronized line.
// Ports   :
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   i_rx       in   asynchronous serial line, idle high
//   o_rx_sync  out  synchronized rx
//   o_fall     out  one-cycle flag: synchronized rx went high -> low
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_rx_sync,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    // r_live marks which stages hold a real pin sample rather than a reset 1
    logic [SYNC_STAGES-1:0] r_live;
    logic                   r_prev;
    logic                   r_armed;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync  <= '1;
            r_live  <= '0;
            r_prev  <= 1'b1;
            r_armed <= 1'b0;
        end else begin
            r_sync[0] <= i_rx;
            r_live[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
                r_live[i] <= r_live[i-1];
            end
            r_prev <= w_sync;
            // After reset the line must first be seen high from the pin itself;
            // a line that is already low (mid-frame) must not look like a new edge.
            if (r_live[SYNC_STAGES-1] && w_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_rx_sync = w_sync;
    assign o_fall    = r_armed & r_prev & ~w_sync;

endmodule

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 UART receiver with majority-vote bit sampling
//
// Purpose : receive 1 start / 8 data (LSB first) / 1 stop frames and hand
//           each byte over with a valid/ready handshake.
// Ports   :
//   clk        in   system clock, all logic on posedge
//   rst_n      in   synchronous active-low reset
//   rx         in   asynchronous serial line, idle high
//   rx_byte    out  last received byte
//   rx_valid   out  rx_byte holds an unconsumed byte
//   rx_ready   in   consumer takes rx_byte when rx_valid & rx_ready
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   overrun    out  one-cycle pulse, byte overwritten before consumption
//   busy       out  receiver is not idle
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // Three votes straddle the middle of each bit period
    localparam logic [CNT_W-1:0] VOTE_A   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] VOTE_B   = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] VOTE_C   = CNT_W'(CLKS_PER_BIT / 2 + 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_vote_a;
    logic             r_vote_b;
    logic [7:0]       r_rx_byte;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_rx_sync;
    logic             w_fall;
    logic             w_vote;
    logic             w_decide;
    logic             w_load;
    logic [CNT_W-1:0] w_cnt_next;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rx      (rx),
        .o_rx_sync (w_rx_sync),
        .o_fall    (w_fall)
    );

    // Third vote is the live synchronized sample, so the decision lands on VOTE_C
    assign w_vote     = maj3(r_vote_a, r_vote_b, w_rx_sync);
    assign w_decide   = (r_cnt == VOTE_C);
    assign w_cnt_next = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
    assign w_load     = (r_state == ST_STOP) && w_decide && w_vote;

    // Frame decoding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_vote_a    <= 1'b1;
            r_vote_b    <= 1'b1;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;

            if (r_cnt == VOTE_A) begin
                r_vote_a <= w_rx_sync;
            end
            if (r_cnt == VOTE_B) begin
                r_vote_b <= w_rx_sync;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= ST_START;
                    end
                end

                ST_START: begin
                    r_cnt <= w_cnt_next;
                    if (w_decide) begin
                        // A start bit that votes high was only a glitch
                        r_state <= w_vote ? ST_IDLE : ST_DATA;
                    end
                end

                ST_DATA: begin
                    r_cnt <= w_cnt_next;
                    if (w_decide) begin
                        r_shift   <= {w_vote, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end
                end

                ST_STOP: begin
                    r_cnt <= w_cnt_next;
                    if (w_decide) begin
                        if (w_vote) begin
                            // Leave mid stop bit so a back-to-back start edge is caught
                            r_state <= ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end
                    end
                end

                ST_BREAK: begin
                    // Hold here while the line stays low so a break reports only once
                    if (w_rx_sync) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output handshake: a load wins over a same-cycle consume
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_byte  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_load) begin
                r_rx_byte  <= r_shift;
                r_rx_valid <= 1'b1;
                r_overrun  <= r_rx_valid & ~rx_ready;
            end else begin
                r_overrun <= 1'b0;
                if (rx_ready) begin
                    r_rx_valid <= 1'b0;
                end
            end
        end
    end

    assign rx_byte   = r_rx_byte;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb/tb_uart_rx_8n1.sv - scoreboard bench for uart_rx_8n1
module tb_uart_rx_8n1;

    localparam int CPB_MAIN = 40;
    localparam int CPB_REF  = 1250;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_main, rx_ref;
    logic       ready_main, ready_ref;
    logic [7:0] rx_byte_m, rx_byte_r;
    logic       rx_valid_m, rx_valid_r;
    logic       ferr_m, ferr_r, ovr_m, ovr_r, busy_m, busy_r;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] q_main[$];
    logic [7:0] q_ref[$];
    int         n_ferr_main = 0, n_ovr_main = 0;
    int         n_ferr_ref = 0, n_valid_ref = 0;
    int         ref_rise_cyc = -1;
    int         fall_cyc = 0;
    logic       prev_valid_ref = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB_MAIN), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .rx(rx_main), .rx_byte(rx_byte_m), .rx_valid(rx_valid_m),
        .rx_ready(ready_main), .frame_err(ferr_m), .overrun(ovr_m), .busy(busy_m)
    );

    uart_rx_8n1 u_dut_ref (
        .clk(clk), .rst_n(rst_n), .rx(rx_ref), .rx_byte(rx_byte_r), .rx_valid(rx_valid_r),
        .rx_ready(ready_ref), .frame_err(ferr_r), .overrun(ovr_r), .busy(busy_r)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitors, sampling on the falling edge
    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (rst_n) begin
            if (rx_valid_m && ready_main) begin
                if (q_main.size() == 0) check_eq("main_unexpected_byte", q_main.size(), 1);
                else begin
                    e = q_main.pop_front();
                    check_eq("main_byte", rx_byte_m, e);
                end
            end
            if (ovr_m) begin
                n_ovr_main++;
                if (q_main.size() > 0) void'(q_main.pop_front());
            end
            if (ferr_m) n_ferr_main++;

            if (rx_valid_r && ready_ref) begin
                if (q_ref.size() == 0) check_eq("ref_unexpected_byte", q_ref.size(), 1);
                else begin
                    e = q_ref.pop_front();
                    check_eq("ref_byte", rx_byte_r, e);
                end
            end
            if (rx_valid_r) n_valid_ref++;
            if (rx_valid_r && !prev_valid_ref) ref_rise_cyc = cyc;
            prev_valid_ref = rx_valid_r;
            if (ferr_r) n_ferr_ref++;
        end
    end

    // Drives one frame from a negedge; spike_bit inverts one cycle just past mid-bit
    task automatic send_frame(input bit to_ref, input logic [7:0] data, input bit stop_bit,
                              input int spike_bit);
        int         cpb;
        logic [9:0] bits;
        logic       v;
        cpb      = to_ref ? CPB_REF : CPB_MAIN;
        bits     = {stop_bit, data, 1'b0};
        fall_cyc = cyc + 1;
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < cpb; j++) begin
                v = bits[b];
                if (b == spike_bit && j == cpb / 2 + 1) v = ~v;
                if (to_ref) rx_ref = v;
                else        rx_main = v;
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_drain_main(input string tag);
        for (int i = 0; i < 20 * CPB_MAIN && q_main.size() != 0; i++) @(negedge clk);
        check_eq(tag, q_main.size(), 0);
    endtask

    task automatic set_ready_main(input logic v);
        @(posedge clk);
        #1 ready_main = v;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        string hello;
        int    lat, base;
        hello = "Hello, world!\n\r";
        rst_n = 1'b0; rx_main = 1'b1; rx_ref = 1'b1; ready_main = 1'b1; ready_ref = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_rx_valid", rx_valid_m, 0);
        check_eq("rst_rx_byte", rx_byte_m, 8'h00);
        check_eq("rst_frame_err", ferr_m, 0);
        check_eq("rst_overrun", ovr_m, 0);
        check_eq("rst_busy", busy_m, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 0x48 at the default bit period: byte, one-cycle valid, latency
        n_valid_ref = 0;
        q_ref.push_back(8'h48);
        send_frame(1'b1, 8'h48, 1'b1, -1);
        repeat (200) @(negedge clk);
        lat = ref_rise_cyc - fall_cyc;
        $display("info: ref latency %0d cycles", lat);
        check_eq("ref_drain", q_ref.size(), 0);
        check_eq("ref_valid_cycles", n_valid_ref, 1);
        check_eq("ref_latency_in_11871_11879", (lat >= 11871 && lat <= 11879), 1);
        check_eq("ref_no_ferr", n_ferr_ref, 0);

        // 400-cycle low glitch on idle line
        n_valid_ref = 0;
        rx_ref = 1'b0;
        repeat (200) @(negedge clk);
        check_eq("glitch_busy_high", busy_r, 1);
        repeat (200) @(negedge clk);
        rx_ref = 1'b1;
        repeat (1000) @(negedge clk);
        check_eq("glitch_busy_low", busy_r, 0);
        check_eq("glitch_no_valid", n_valid_ref, 0);
        check_eq("glitch_no_ferr", n_ferr_ref, 0);

        // Back-to-back string
        for (int i = 0; i < hello.len(); i++) begin
            q_main.push_back(hello[i]);
            send_frame(1'b0, hello[i], 1'b1, -1);
        end
        wait_drain_main("hello_drain");
        check_eq("hello_no_ferr", n_ferr_main, 0);
        check_eq("hello_no_overrun", n_ovr_main, 0);

        // Single-cycle spikes at the votes of 0xF0 (start bit, data bit 4)
        q_main.push_back(8'hF0);
        send_frame(1'b0, 8'hF0, 1'b1, 0);
        q_main.push_back(8'hF0);
        send_frame(1'b0, 8'hF0, 1'b1, 5);
        wait_drain_main("spike_drain");

        // Overrun: 0x55 then 0xAA unconsumed
        set_ready_main(1'b0);
        base = n_ovr_main;
        q_main.push_back(8'h55);
        send_frame(1'b0, 8'h55, 1'b1, -1);
        q_main.push_back(8'hAA);
        send_frame(1'b0, 8'hAA, 1'b1, -1);
        repeat (10) @(negedge clk);
        check_eq("ovr_valid", rx_valid_m, 1);
        check_eq("ovr_byte", rx_byte_m, 8'hAA);
        check_eq("ovr_pulses", n_ovr_main - base, 1);
        check_eq("ovr_sb_pending", q_main.size(), 1);
        @(posedge clk); #1 ready_main = 1'b1;
        @(posedge clk); #1 ready_main = 1'b0;
        @(negedge clk);
        check_eq("ovr_valid_cleared", rx_valid_m, 0);
        check_eq("ovr_sb_empty", q_main.size(), 0);
        set_ready_main(1'b1);

        // Framing error then a held-low line, then a good frame
        base = n_ferr_main;
        send_frame(1'b0, 8'h00, 1'b0, -1);
        rx_main = 1'b0;
        repeat (3 * CPB_MAIN) @(negedge clk);
        rx_main = 1'b1;
        repeat (2 * CPB_MAIN) @(negedge clk);
        check_eq("ferr_pulses", n_ferr_main - base, 1);
        check_eq("ferr_no_valid", rx_valid_m, 0);
        check_eq("ferr_busy_low", busy_m, 0);
        q_main.push_back(8'h31);
        send_frame(1'b0, 8'h31, 1'b1, -1);
        wait_drain_main("ferr_next_drain");

        // Reset during data bit 4 of an all-zero frame
        base = n_ferr_main;
        rx_main = 1'b0;
        repeat (5 * CPB_MAIN + CPB_MAIN / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", busy_m, 0);
        check_eq("midrst_valid", rx_valid_m, 0);
        rst_n = 1'b1;
        repeat (CPB_MAIN / 2 + 3 * CPB_MAIN) @(negedge clk);
        rx_main = 1'b1;
        repeat (3 * CPB_MAIN) @(negedge clk);
        check_eq("midrst_idle", busy_m, 0);
        check_eq("midrst_no_ferr", n_ferr_main - base, 0);
        q_main.push_back(8'h7E);
        send_frame(1'b0, 8'h7E, 1'b1, -1);
        wait_drain_main("midrst_drain");
        check_eq("final_no_overrun", n_ovr_main, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
